// File: rtl/sh_intc_gen.sv
// sh_intc_gen: prioritised interrupt controller for a SuperH-style CPU.
//
// Each peripheral source has a config word (level, vector, edge mode) in a
// 32-bit register window. Pending sources are arbitrated by level, with ties
// going to the lowest index. The winner is presented to the CPU as
// INT_REQ/INT_LVL/INT_VEC/INT_SRC when its level exceeds the SR mask.
//
// Optional feature: define SH_INTC_GEN_EDGE_EN to enable per-source edge mode
// (config bit 16). Without it every source is level-sensitive, bit 16 reads 0
// and no edge-history flops are built.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   SRC_IRQ            per-source request, active-high
//   INT_MASK           CPU SR interrupt mask
//   INT_ACK            one-cycle CPU acceptance of the current request
//   INT_REQ            request to CPU (high exactly in the REQ state)
//   INT_LVL/VEC/SRC    level, vector and source index of the current request
//   REG_A              byte address of the register window (4 bytes/source)
//   REG_DI, REG_WE     write data and write strobe
//   REG_REQ            access strobe
//   REG_DO             registered read data
module sh_intc_gen #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned LVL_W   = 4,
    parameter int unsigned VEC_W   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] SRC_IRQ,
    input  logic [LVL_W-1:0]   INT_MASK,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [LVL_W-1:0]   INT_LVL,
    output logic [VEC_W-1:0]   INT_VEC,
    output logic [4:0]         INT_SRC,
    input  logic [7:0]         REG_A,
    input  logic [31:0]        REG_DI,
    input  logic               REG_WE,
    input  logic               REG_REQ,
    output logic [31:0]        REG_DO
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e state_q, state_d;

    // Per-source configuration
    logic [LVL_W-1:0] lvl_q [NUM_SRC];
    logic [7:0]       vec_q [NUM_SRC];

    // Register window decode; REG_A[1:0] is ignored (word-granular window)
    logic [5:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [31:0] reg_do_q;
    logic        unused_a;
    logic        unused_di;

    assign reg_idx   = REG_A[7:2];
    assign wr_en     = REG_REQ & REG_WE;
    assign rd_en     = REG_REQ & ~REG_WE;
    assign unused_a  = ^REG_A[1:0];
    assign unused_di = ^REG_DI;

    // Pending vector and arbitration results
    logic [NUM_SRC-1:0] pend;
    logic [LVL_W-1:0]   cand_lvl;
    logic [7:0]         cand_vec;
    logic [4:0]         cand_src;
    logic               cand_valid;

    // Latched request and live status of the latched source
    logic [LVL_W-1:0] int_lvl_q;
    logic [VEC_W-1:0] int_vec_q;
    logic [4:0]       int_src_q;
    logic [LVL_W-1:0] cur_lvl;
    logic             cur_pend;
    logic             latch_en;
    logic             ack_take;

    assign ack_take = INT_ACK & (state_q == StReq);

    // Config registers: out-of-range indices match no entry, so writes vanish
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                lvl_q[i] <= '0;
                vec_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reg_idx == 6'(i)) begin
                    lvl_q[i] <= REG_DI[LVL_W-1:0];
                    vec_q[i] <= REG_DI[15:8];
                end
            end
        end
    end

`ifdef SH_INTC_GEN_EDGE_EN
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] irq_hist_q;
    logic [NUM_SRC-1:0] pend_edge_q;
    logic [NUM_SRC-1:0] pend_edge_d;
    logic [NUM_SRC-1:0] ack_clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            edge_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reg_idx == 6'(i)) begin
                    edge_q[i] <= REG_DI[16];
                end
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_take & (int_src_q == 5'(i));
        end
    end

    // A fresh rising edge outranks the acknowledge clear in the same cycle
    assign pend_edge_d = edge_q & ((SRC_IRQ & ~irq_hist_q) | (pend_edge_q & ~ack_clr));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_hist_q  <= '0;
            pend_edge_q <= '0;
        end else begin
            irq_hist_q  <= SRC_IRQ;
            pend_edge_q <= pend_edge_d;
        end
    end

    assign pend = (edge_q & pend_edge_q) | (~edge_q & SRC_IRQ);
`else
    assign pend = SRC_IRQ;
`endif

    // Read mux
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_idx == 6'(i)) begin
                rd_data[LVL_W-1:0] = lvl_q[i];
                rd_data[15:8]      = vec_q[i];
`ifdef SH_INTC_GEN_EDGE_EN
                rd_data[16]        = edge_q[i];
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_do_q <= '0;
        end else if (rd_en) begin
            reg_do_q <= rd_data;
        end
    end

    assign REG_DO = reg_do_q;

    // Strict '>' keeps the lowest index on equal levels; level 0 never wins
    always_comb begin
        cand_lvl = '0;
        cand_vec = '0;
        cand_src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && (lvl_q[i] > cand_lvl)) begin
                cand_lvl = lvl_q[i];
                cand_vec = vec_q[i];
                cand_src = 5'(i);
            end
        end
    end

    assign cand_valid = cand_lvl > INT_MASK;

    // Live config/pending of the latched source (config writes apply here at once)
    always_comb begin
        cur_lvl  = '0;
        cur_pend = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int_src_q == 5'(i)) begin
                cur_lvl  = lvl_q[i];
                cur_pend = pend[i];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state and latch enable
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    state_d  = StReq;
                    latch_en = 1'b1;
                end
            end
            StReq: begin
                if (INT_ACK) begin
                    state_d = StIdle;
                end else if (!cur_pend || (cur_lvl <= INT_MASK)) begin
                    state_d = StIdle;
                end else if (cand_valid && (cand_lvl > int_lvl_q)) begin
                    latch_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Latched request data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            int_lvl_q <= '0;
            int_vec_q <= '0;
            int_src_q <= '0;
        end else if (latch_en) begin
            int_lvl_q <= cand_lvl;
            int_vec_q <= VEC_W'(cand_vec);
            int_src_q <= cand_src;
        end
    end

    // FSM: outputs
    always_comb begin
        INT_REQ = (state_q == StReq);
        INT_LVL = int_lvl_q;
        INT_VEC = int_vec_q;
        INT_SRC = int_src_q;
    end

endmodule

// File: tb/tb_sh_intc_gen.sv
// Scoreboard bench for sh_intc_gen (default parameters). Stimulus pushes the
// expected interrupt events (with the cycle they must appear) and expected read
// data; a monitor pops and compares whenever the DUT presents an event.
module tb_sh_intc_gen;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] SRC_IRQ;
    logic [3:0]  INT_MASK;
    logic        INT_ACK;
    logic        INT_REQ;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic [4:0]  INT_SRC;
    logic [7:0]  REG_A;
    logic [31:0] REG_DI;
    logic        REG_WE;
    logic        REG_REQ;
    logic [31:0] REG_DO;

    sh_intc_gen dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SRC_IRQ  (SRC_IRQ),
        .INT_MASK (INT_MASK),
        .INT_ACK  (INT_ACK),
        .INT_REQ  (INT_REQ),
        .INT_LVL  (INT_LVL),
        .INT_VEC  (INT_VEC),
        .INT_SRC  (INT_SRC),
        .REG_A    (REG_A),
        .REG_DI   (REG_DI),
        .REG_WE   (REG_WE),
        .REG_REQ  (REG_REQ),
        .REG_DO   (REG_DO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         req;
        logic [3:0] lvl;
        logic [7:0] vec;
        logic [4:0] src;
        int         due;
    } int_exp_t;

    int_exp_t    int_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

`ifdef SH_INTC_GEN_EDGE_EN
    localparam logic [31:0] AllOnesRb = 32'h0001FF0F;
`else
    localparam logic [31:0] AllOnesRb = 32'h0000FF0F;
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_int(input bit req, input logic [3:0] lvl, input logic [7:0] vec,
                              input logic [4:0] src, input int lat);
        int_exp_t e;
        e.req = req;
        e.lvl = lvl;
        e.vec = vec;
        e.src = src;
        e.due = cyc + lat;
        int_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        REG_A   = a;
        REG_DI  = d;
        REG_WE  = 1'b1;
        REG_REQ = 1'b1;
        tick();
        REG_WE  = 1'b0;
        REG_REQ = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp_d);
        REG_A   = a;
        REG_WE  = 1'b0;
        REG_REQ = 1'b1;
        rd_q.push_back(exp_d);
        tick();
        REG_REQ = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: counts cycles, checks read data and every change of the request
    initial begin : monitor
        logic        rd_now;
        logic        prev_req;
        logic [16:0] prev_tup;
        logic [31:0] exp_d;
        int_exp_t    e;
        prev_req = 1'b0;
        prev_tup = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            rd_now = RST_N && REG_REQ && !REG_WE;
            @(negedge CLK);
            if (rd_now) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read: got %h with no read expected", REG_DO);
                end else begin
                    exp_d = rd_q.pop_front();
                    if (REG_DO !== exp_d) begin
                        errors++;
                        $display("FAIL read: got %h, expected %h", REG_DO, exp_d);
                    end
                end
            end
            if ((INT_REQ !== prev_req) ||
                (INT_REQ && ({INT_LVL, INT_VEC, INT_SRC} !== prev_tup))) begin
                checks++;
                if (int_q.size() == 0) begin
                    errors++;
                    $display("FAIL int_event: unexpected req=%0b lvl=%0d vec=%h src=%0d cyc=%0d",
                             INT_REQ, INT_LVL, INT_VEC, INT_SRC, cyc);
                end else begin
                    e = int_q.pop_front();
                    if ((INT_REQ !== e.req) || (cyc != e.due) ||
                        (e.req && ({INT_LVL, INT_VEC, INT_SRC} !== {e.lvl, e.vec, e.src}))) begin
                        errors++;
                        $display("FAIL int_event: got req=%0b lvl=%0d vec=%h src=%0d cyc=%0d, expected req=%0b lvl=%0d vec=%h src=%0d cyc=%0d",
                                 INT_REQ, INT_LVL, INT_VEC, INT_SRC, cyc,
                                 e.req, e.lvl, e.vec, e.src, e.due);
                    end
                end
            end
            prev_req = INT_REQ;
            prev_tup = {INT_LVL, INT_VEC, INT_SRC};
        end
    end

    initial begin : stimulus
        RST_N    = 1'b0;
        SRC_IRQ  = '0;
        INT_MASK = 4'd2;
        INT_ACK  = 1'b0;
        REG_A    = '0;
        REG_DI   = '0;
        REG_WE   = 1'b0;
        REG_REQ  = 1'b0;
        repeat (2) tick();
        chk("reset_int_req", 32'(INT_REQ), 32'd0);
        chk("reset_int_lvl", 32'(INT_LVL), 32'd0);
        chk("reset_int_vec", 32'(INT_VEC), 32'd0);
        chk("reset_int_src", 32'(INT_SRC), 32'd0);
        chk("reset_reg_do", REG_DO, 32'd0);
        RST_N = 1'b1;
        tick();

        // Register window: unused bits read 0, out-of-range ignored
        wr(8'h00, 32'hFFFF_FFFF);
        rd(8'h00, AllOnesRb);
        wr(8'h40, 32'h0000_1234);
        rd(8'h40, 32'h0);
        wr(8'h0C, 32'h0000_4505);
        rd(8'h0C, 32'h0000_4505);

        // Single source, one-cycle latency; ack with source dropped
        SRC_IRQ[3] = 1'b1;
        expect_int(1'b1, 4'd5, 8'h45, 5'd3, 1);
        repeat (2) tick();
        INT_ACK    = 1'b1;
        SRC_IRQ[3] = 1'b0;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        tick();
        INT_ACK = 1'b0;
        tick();

        // Tie on level 9 goes to lowest index, then the other follows after ack
        wr(8'h08, 32'h0000_2209);
        wr(8'h1C, 32'h0000_7709);
        SRC_IRQ[2] = 1'b1;
        SRC_IRQ[7] = 1'b1;
        expect_int(1'b1, 4'd9, 8'h22, 5'd2, 1);
        repeat (2) tick();
        INT_ACK    = 1'b1;
        SRC_IRQ[2] = 1'b0;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        expect_int(1'b1, 4'd9, 8'h77, 5'd7, 2);
        tick();
        INT_ACK = 1'b0;
        repeat (2) tick();
        INT_ACK    = 1'b1;
        SRC_IRQ[7] = 1'b0;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        tick();
        INT_ACK = 1'b0;
        tick();

        // Preemption by a higher level; equal level does not preempt
        wr(8'h04, 32'h0000_1104);
        wr(8'h14, 32'h0000_550C);
        wr(8'h18, 32'h0000_660C);
        SRC_IRQ[1] = 1'b1;
        expect_int(1'b1, 4'd4, 8'h11, 5'd1, 1);
        repeat (2) tick();
        SRC_IRQ[5] = 1'b1;
        expect_int(1'b1, 4'd12, 8'h55, 5'd5, 1);
        repeat (2) tick();
        SRC_IRQ[6] = 1'b1;
        repeat (3) tick();
        SRC_IRQ[5] = 1'b0;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        expect_int(1'b1, 4'd12, 8'h66, 5'd6, 2);
        repeat (3) tick();
        SRC_IRQ[1] = 1'b0;
        SRC_IRQ[6] = 1'b0;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        repeat (2) tick();

        // Mask: level must strictly exceed INT_MASK; 15 blocks everything
        wr(8'h00, 32'h0000_0A06);
        SRC_IRQ[0] = 1'b1;
        expect_int(1'b1, 4'd6, 8'h0A, 5'd0, 1);
        repeat (2) tick();
        INT_MASK = 4'd6;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        repeat (3) tick();
        INT_MASK = 4'd5;
        expect_int(1'b1, 4'd6, 8'h0A, 5'd0, 1);
        repeat (2) tick();
        INT_MASK = 4'd15;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        tick();
        SRC_IRQ = 16'hFFFF;
        repeat (3) tick();
        SRC_IRQ = '0;
        tick();
        INT_MASK = 4'd2;
        repeat (2) tick();

        // Config write to the latched source: withdrawal the cycle after it lands
        SRC_IRQ[3] = 1'b1;
        expect_int(1'b1, 4'd5, 8'h45, 5'd3, 1);
        repeat (2) tick();
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 2);
        wr(8'h0C, 32'h0000_9902);
        repeat (2) tick();
        SRC_IRQ[3] = 1'b0;
        tick();

`ifdef SH_INTC_GEN_EDGE_EN
        // Edge source: pulse is held until ack; re-pulse during ack sticks
        wr(8'h10, 32'h0001_4407);
        SRC_IRQ[4] = 1'b1;
        expect_int(1'b1, 4'd7, 8'h44, 5'd4, 2);
        tick();
        SRC_IRQ[4] = 1'b0;
        repeat (4) tick();
        INT_ACK    = 1'b1;
        SRC_IRQ[4] = 1'b1;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        expect_int(1'b1, 4'd7, 8'h44, 5'd4, 2);
        tick();
        INT_ACK    = 1'b0;
        SRC_IRQ[4] = 1'b0;
        repeat (3) tick();
        INT_ACK = 1'b1;
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 1);
        tick();
        INT_ACK = 1'b0;
        repeat (3) tick();
`endif

        // Asynchronous reset in the middle of a request
        SRC_IRQ[2] = 1'b1;
        expect_int(1'b1, 4'd9, 8'h22, 5'd2, 1);
        repeat (2) tick();
        expect_int(1'b0, 4'd0, 8'h00, 5'd0, 0);
        RST_N = 1'b0;
        #1;
        chk("async_rst_int_req", 32'(INT_REQ), 32'd0);
        chk("async_rst_int_lvl", 32'(INT_LVL), 32'd0);
        chk("async_rst_int_vec", 32'(INT_VEC), 32'd0);
        chk("async_rst_int_src", 32'(INT_SRC), 32'd0);
        chk("async_rst_reg_do", REG_DO, 32'd0);
        tick();
        SRC_IRQ = '0;
        RST_N   = 1'b1;
        tick();
        rd(8'h08, 32'h0);
        rd(8'h1C, 32'h0);
        repeat (3) tick();

        chk("int_queue_drained", 32'(int_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sh_intc_gen.md
SH_INTC_GEN -- requirements
Module: sh_intc_gen

Interface
REQ-001 The block SHALL take parameter NUM_SRC, default 16, the number of peripheral interrupt sources (1..32).
REQ-002 The block SHALL take parameter LVL_W, default 4, the priority level width; level 0 means the source is disabled.
REQ-003 The block SHALL take parameter VEC_W, default 8, the vector number width.
REQ-004 The block SHALL use reset RST_N, asynchronous, active-low, and clock CLK.
REQ-005 Ports SHALL be:
- CLK  in  1  clock
- RST_N  in  1  async reset, active-low
- SRC_IRQ  in  NUM_SRC  per-source request, active-high
- INT_MASK  in  LVL_W  CPU SR interrupt mask
- INT_ACK  in  1  one-cycle CPU acceptance of the current request
- INT_REQ  out  1  request to CPU
- INT_LVL  out  LVL_W  level of the current request
- INT_VEC  out  VEC_W  vector of the current request
- INT_SRC  out  5  index of the current source
- REG_A  in  8  byte address of the register window
- REG_DI  in  32  write data
- REG_WE  in  1  write strobe
- REG_REQ  in  1  access strobe
- REG_DO  out  32  read data, registered

Function
REQ-006 Each source i SHALL own a 32-bit config register at REG_A = 4*i: [LVL_W-1:0] level, [15:8] vector, bit 16 edge mode; all other bits read 0; REG_A at or beyond 4*NUM_SRC reads 0 and ignores writes.
REQ-007 A write SHALL occur on a CLK edge where REG_REQ=1 and REG_WE=1; a read SHALL update REG_DO on the edge where REG_REQ=1 and REG_WE=0; otherwise REG_DO SHALL hold.
REQ-008 Pending bit PEND[i] SHALL be SRC_IRQ[i] in level mode; in edge mode it SHALL set on a registered 0->1 transition of SRC_IRQ[i] and clear only on an INT_ACK naming source i.
REQ-009 The arbiter SHALL select the pending source with the highest nonzero level; ties SHALL go to the lowest index; a candidate SHALL be valid only when its level > INT_MASK.
REQ-010 The FSM SHALL have states IDLE and REQ; reset state IDLE.
REQ-011 From IDLE with a valid candidate, the next edge SHALL enter REQ and latch INT_LVL, INT_VEC and INT_SRC from it; INT_REQ=1 exactly in REQ (one-cycle latency).
REQ-012 In REQ without INT_ACK, a valid candidate with a strictly higher level SHALL replace the latched values on the next edge (preemption); equal levels SHALL NOT preempt.
REQ-013 In REQ, when the latched source is no longer pending or its level <= INT_MASK and INT_ACK=0, the FSM SHALL return to IDLE on the next edge (request withdrawal).
REQ-014 INT_ACK in REQ SHALL return the FSM to IDLE on the next edge and clear the edge-mode pending bit of INT_SRC; INT_ACK in IDLE SHALL be ignored.
REQ-015 A new edge on the same source in the cycle INT_ACK clears it SHALL leave PEND set (set wins).
REQ-016 A config write to the latched source while in REQ SHALL take effect for arbitration from the next cycle; INT_LVL and INT_VEC SHALL not change until relatched.

Reset
REQ-017 On RST_N low: FSM=IDLE; INT_REQ=0; INT_LVL=0; INT_VEC=0; INT_SRC=0; REG_DO=0; all config registers=0; PEND=0; edge history=0.
REQ-018 Reset asserted mid-REQ SHALL drop INT_REQ asynchronously with no acknowledge required.

Configuration
REQ-019 With macro SH_INTC_GEN_EDGE_EN defined, bit 16 SHALL select edge mode per REQ-008; without it, bit 16 SHALL be read-only 0, all sources level-mode, and no edge-history flops SHALL exist.

Verification
REQ-020 Src 3 level 5 vector 0x45, INT_MASK=2, SRC_IRQ[3]=1 -> INT_REQ=1 one cycle later, INT_LVL=5, INT_VEC=0x45, INT_SRC=3.
REQ-021 Src 2 and 7 both level 9, raised together -> INT_SRC=2; after INT_ACK with src 2 deasserted -> IDLE, then INT_SRC=7.
REQ-022 In REQ with src 1 level 4, src 5 level 12 rises before ack -> INT_LVL=12, INT_VEC=src 5 vector next cycle, INT_REQ stays 1.
REQ-023 Src 0 level 6, INT_MASK raised 2->6 during REQ -> INT_REQ=0 next cycle; mask 15 blocks all sources.
REQ-024 (SH_INTC_GEN_EDGE_EN) Edge src 4 pulsed for one cycle -> request held until INT_ACK; second pulse coinciding with ACK -> new request follows.
REQ-025 Write 0xFFFFFFFF to REG_A=0x00, read back -> 0x0001FF0F (0x0000FF0F without macro); RST_N low mid-REQ -> all outputs 0 immediately.
